monitor_trace_buf: RTL
======================

# monitor_trace_buf

Multi-entry trace buffer for the monitor: a parametrised successor to the single W-register watch capture. It records a history of MWL bus values, each with a timing and pulse tag, into a ring buffer of DEPTH entries. An arm / trigger / post-count state machine freezes the buffer around a trigger event. The host then drains the buffer oldest-first through the monitor register read bus.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, 4..256.
- BASE_ADDR, 16'h0040, first of four read addresses.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ct  in  1  capture strobe; same qualifier the monitor registers use to latch MWL.
- mt  in  12  timepulse one-hot, bits [12:1].
- mwl  in  16  monitor write lines, bits [16:1].
- agc_pulses  in  12  pulse vector, same bit order as the W-register pulse select.
- s_match  in  1  S-address comparator hit.
- i_match  in  1  instruction comparator hit.
- pulse_mask  in  12  a capture needs at least one selected pulse; 0 means any ct.
- time_mask  in  12  a capture needs at least one selected timepulse; 0 means any.
- trig_mode  in  2  trigger source: 0 = immediate, 1 = s_match, 2 = i_match, 3 = s_match & i_match.
- post_count  in  log2(DEPTH)+1  number of entries captured after the trigger entry; clamped to DEPTH-1.
- arm  in  1  single-cycle start.
- clear  in  1  single-cycle abort/flush.
- trace_state  out  2  0 = IDLE, 1 = ARMED, 2 = TRIGGERED, 3 = DONE.
- read_en  in  1  register read strobe.
- addr  in  16  read address.
- data_out  out  16  read data.

## Operation
- cap = ct & (pulse_mask==0 | (pulse_mask & agc_pulses)!=0) & (time_mask==0 | (time_mask & mt)!=0).
- trig_hit = cap & trigger source per trig_mode.
- Each entry stores data = mwl and tag = {trig_flag, mt_code[3:0], agc_pulses[10:0]}.
  - mt_code is the index 1..12 of the lowest set mt bit, or 0 if none.
  - trig_flag is 1 only on the trigger entry.
- Storage: wr_ptr, rd_ptr and count (0..DEPTH), all log2 wide except count.
- IDLE:
  - No captures.
  - arm clears pointers and count, then goes to ARMED.
  - Pops are allowed (see read side).
- ARMED:
  - Every cap writes one entry.
  - When count==DEPTH the write overwrites the oldest entry: rd_ptr advances and count holds.
  - trig_hit writes the entry with trig_flag=1.
  - If post_count==0 the next state is DONE; otherwise TRIGGERED with remaining = post_count.
- TRIGGERED:
  - Each cap writes an entry (overwrite rule as above) and decrements remaining.
  - When remaining reaches 0 the state goes to DONE.
  - Further trig_hit is ignored apart from the capture itself.
- DONE: captures are frozen; only clear or arm leave this state.
- arm in any state restarts exactly as from IDLE.
- clear in any state: go to IDLE, count=0, pointers=0.
- If clear and arm occur together, clear wins.
- Read side: read_en is registered to read_en_q, and data_out is combinational from read_en_q and addr.
  - BASE+0 STATUS: {trace_state, 5'b0, count[8:0]}.
  - BASE+1 DATA: entry data at rd_ptr.
  - BASE+2 TAG: entry tag at rd_ptr.
  - BASE+3 WRPTR: {8'b0, wr_ptr zero-extended}.
  - Other addresses, or read_en_q=0: data_out = 0.
- Pop: a read_en_q cycle at BASE+2 (TAG) in IDLE or DONE with count>0 advances rd_ptr and decrements count at the end of that cycle.
  - Host reads DATA then TAG per entry.
  - Pops in ARMED or TRIGGERED are ignored.
  - Reads with count==0 return 0 and do not pop.

## Timing
- Reset values:
  - trace_state = IDLE.
  - Pointers, count, remaining and read_en_q = 0.
  - data_out = 0.
  - Entry storage is not reset.
- Capture latency: an entry written on edge N is readable via a read_en asserted at edge N or later. data_out is valid in the cycle after read_en.
- State change takes effect on the edge where cap, arm or clear is sampled. trace_state reflects it the following cycle.
- Wrap-around: pointers roll DEPTH-1 -> 0. Count saturates at DEPTH with no error.
- A pop and a capture in the same cycle cannot occur, because the two are restricted to disjoint states.
- Asynchronous reset mid-capture discards all entries and forces IDLE.

## Test plan
- DEPTH=8, trig_mode=0, post_count=3, pulse_mask=0, 5 ct pulses with mwl=1..5.
  - Required: DONE after the 4th ct; count=4; DATA/TAG pops give 1(trig_flag=1), 2, 3, 4; the 5th value is not stored.
- trig_mode=1, 12 caps with mwl=10..21, s_match on the value-19 cycle, post_count=2.
  - Required: count=8; pops give 14..21; the entry with value 19 has tag[15]=1.
- pulse_mask selecting bit 0 only, time_mask=mt[5]; ct with agc_pulses=0x002, then 0x001 at mt[3], then 0x001 at mt[5], mwl=0xBEEF.
  - Required: exactly one entry; tag mt_code=5, tag[10:0]=0x001.
- Pop 9 times after the second scenario.
  - Required: first 8 pops return data; the 9th read returns 0; count stays 0.
- clear and arm asserted in the same cycle while TRIGGERED.
  - Required: IDLE, STATUS=0x0000.
- Assert rst_n=0 asynchronously between clock edges while ARMED with count=5.
  - Required: trace_state=0, count=0 and data_out=0 immediately.

Source files
------------

// File: rtl/monitor_trace_buf.sv
// Ring-buffer trace of MWL captures with arm/trigger/post-count freeze and a
// four-register read port that drains entries oldest-first.
module monitor_trace_buf #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [15:0] BASE_ADDR = 16'h0040
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ct,
    input  logic [12:1]              mt,
    input  logic [16:1]              mwl,
    input  logic [11:0]              agc_pulses,
    input  logic                     s_match,
    input  logic                     i_match,
    input  logic [11:0]              pulse_mask,
    input  logic [12:1]              time_mask,
    input  logic [1:0]               trig_mode,
    input  logic [$clog2(DEPTH):0]   post_count,
    input  logic                     arm,
    input  logic                     clear,
    output logic [1:0]               trace_state,
    input  logic                     read_en,
    input  logic [15:0]              addr,
    output logic [15:0]              data_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW:0] MaxPost = CW'(DEPTH - 1);
    localparam logic [AW:0] DepthC  = CW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StTrig  = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e        state_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, remain_q;
    logic          read_en_q;

    logic [15:0] data_mem [DEPTH];
    logic [15:0] tag_mem  [DEPTH];

    logic        pulse_ok, time_ok, cap, trig_src, trig_hit;
    logic        capturing, trig_flag, full, pop;
    logic [3:0]  mt_code;
    logic [AW:0] post_eff;

    assign pulse_ok = (pulse_mask == '0) | ((pulse_mask & agc_pulses) != '0);
    assign time_ok  = (time_mask == '0) | ((time_mask & mt) != '0);
    assign cap      = ct & pulse_ok & time_ok;

    always_comb begin
        unique case (trig_mode)
            2'd0:    trig_src = 1'b1;
            2'd1:    trig_src = s_match;
            2'd2:    trig_src = i_match;
            default: trig_src = s_match & i_match;
        endcase
    end

    assign trig_hit = cap & trig_src;

    // Descending scan so the lowest set timepulse wins.
    always_comb begin
        mt_code = 4'd0;
        for (int i = 12; i >= 1; i--) begin
            if (mt[i]) mt_code = 4'(i);
        end
    end

    assign post_eff  = (post_count > MaxPost) ? MaxPost : post_count;
    assign full      = (count_q == DepthC);
    assign capturing = ~clear & ~arm & cap & ((state_q == StArmed) | (state_q == StTrig));
    assign trig_flag = (state_q == StArmed) & trig_hit;
    assign pop       = read_en_q & (addr == BASE_ADDR + 16'd2) & (count_q != '0) &
                       ((state_q == StIdle) | (state_q == StDone));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            remain_q <= '0;
        end else if (clear) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            remain_q <= '0;
        end else if (arm) begin
            state_q  <= StArmed;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            remain_q <= '0;
        end else if (capturing) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            // A full buffer drops its oldest entry to make room.
            if (full) rd_ptr_q <= rd_ptr_q + 1'b1;
            else      count_q  <= count_q + 1'b1;
            if (state_q == StArmed) begin
                if (trig_hit) begin
                    if (post_eff == '0) begin
                        state_q <= StDone;
                    end else begin
                        state_q  <= StTrig;
                        remain_q <= post_eff;
                    end
                end
            end else begin
                remain_q <= remain_q - 1'b1;
                if (remain_q == CW'(1)) state_q <= StDone;
            end
        end else if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) read_en_q <= 1'b0;
        else        read_en_q <= read_en;
    end

    always_ff @(posedge clk) begin
        if (capturing) begin
            data_mem[wr_ptr_q] <= mwl;
            tag_mem[wr_ptr_q]  <= {trig_flag, mt_code, agc_pulses[10:0]};
        end
    end

    always_comb begin
        data_out = 16'h0000;
        if (read_en_q) begin
            case (addr)
                BASE_ADDR:          data_out = {state_q, 5'b0, 9'(count_q)};
                BASE_ADDR + 16'd1:  data_out = (count_q != '0) ? data_mem[rd_ptr_q] : 16'h0000;
                BASE_ADDR + 16'd2:  data_out = (count_q != '0) ? tag_mem[rd_ptr_q] : 16'h0000;
                BASE_ADDR + 16'd3:  data_out = {8'b0, 8'(wr_ptr_q)};
                default:            data_out = 16'h0000;
            endcase
        end
    end

    assign trace_state = state_q;

endmodule
